// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared constants, sample type and streamer state encoding for
//            the FFT output path.
// Contents : FFT_N / FFT_LOG2N / FFT_SW frame geometry constants,
//            fft_sample_t component type, stream_state_e FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int FFT_SW    = 16;

    typedef logic [FFT_SW-1:0] fft_sample_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_streamer_if
// Purpose  : Bundles the frame-capture handshake and the per-bin output
//            stream of the FFT result streamer.
// Ports    : frame_valid/frame_ready + frame_Re/frame_Im (parallel frame in),
//            out_valid/out_ready + out_Re/out_Im/out_index/out_last (beats),
//            busy (frame held or streaming).
// Modports : master - the streamer itself; slave - producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_result_streamer_if
    import fft_pkg::*;
#(
    parameter int D_WIDTH     = FFT_N,
    parameter int LOG_2_WIDTH = FFT_LOG2N,
    parameter int S_WIDTH     = FFT_SW
);

    logic                   frame_valid;
    logic                   frame_ready;
    logic [S_WIDTH-1:0]     frame_Re [D_WIDTH];
    logic [S_WIDTH-1:0]     frame_Im [D_WIDTH];

    logic                   out_valid;
    logic                   out_ready;
    logic [S_WIDTH-1:0]     out_Re;
    logic [S_WIDTH-1:0]     out_Im;
    logic [LOG_2_WIDTH-1:0] out_index;
    logic                   out_last;
    logic                   busy;

    modport master (
        input  frame_valid, frame_Re, frame_Im, out_ready,
        output frame_ready, out_valid, out_Re, out_Im, out_index, out_last, busy
    );

    modport slave (
        output frame_valid, frame_Re, frame_Im, out_ready,
        input  frame_ready, out_valid, out_Re, out_Im, out_index, out_last, busy
    );

endinterface : fft_result_streamer_if
`default_nettype wire

// File: rtl/bit_reverse_index.sv
`default_nettype none
// ============================================================================
// Module   : bit_reverse_index
// Purpose  : Combinational bit reversal of a LOG_2_WIDTH-bit bin index, used
//            to read a bit-reversed frame buffer in natural bin order.
// Ports    : i_idx (index in), o_idx (bit-reversed index out).
// Config   : only compiled when FFT_STREAM_BITREV_EN is defined, so the
//            natural-order build carries no copy of this module.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef FFT_STREAM_BITREV_EN
module bit_reverse_index #(
    parameter int LOG_2_WIDTH = 6
) (
    input  logic [LOG_2_WIDTH-1:0] i_idx,
    output logic [LOG_2_WIDTH-1:0] o_idx
);

    for (genvar b = 0; b < LOG_2_WIDTH; b++) begin : g_bits
        assign o_idx[b] = i_idx[LOG_2_WIDTH-1-b];
    end

endmodule : bit_reverse_index
`else
`endif
`default_nettype wire

// File: rtl/fft_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fft_result_streamer
// Purpose  : Captures one complete D_WIDTH-point complex FFT frame into a
//            private buffer and drains it as one bin per valid/ready beat,
//            tagging each beat with its bin index and a last flag.
// Ports    : clk, rst (synchronous, active-high)
//            bus (fft_result_streamer_if.master): frame capture handshake,
//            output beat stream, busy status.
// Config   : FFT_STREAM_BITREV_EN - when defined, the buffer is read at
//            bitrev(k) so bit-reversed storage leaves in natural order;
//            when undefined, bin k is read straight from buffer entry k.
// Revision : 1.0 - initial release
// ============================================================================
module fft_result_streamer
    import fft_pkg::*;
#(
    parameter int D_WIDTH     = FFT_N,
    parameter int LOG_2_WIDTH = FFT_LOG2N,
    parameter int S_WIDTH     = FFT_SW
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_result_streamer_if.master bus
);

    localparam logic [LOG_2_WIDTH-1:0] c_last_k = LOG_2_WIDTH'(D_WIDTH - 1);

    stream_state_e          r_state;
    stream_state_e          w_next_state;
    logic                   w_capture;
    logic                   w_advance;
    logic                   w_finish;

    logic [LOG_2_WIDTH-1:0] r_k;
    logic [LOG_2_WIDTH-1:0] w_k_inc;
    logic [LOG_2_WIDTH-1:0] w_src;

    logic                   r_frame_ready;
    logic [S_WIDTH-1:0]     r_buf_re [D_WIDTH];
    logic [S_WIDTH-1:0]     r_buf_im [D_WIDTH];
    logic [S_WIDTH-1:0]     r_out_re;
    logic [S_WIDTH-1:0]     r_out_im;
    logic                   r_out_last;

    // Buffer address for the beat that follows the current one.
    assign w_k_inc = r_k + 1'b1;

`ifdef FFT_STREAM_BITREV_EN
    bit_reverse_index #(
        .LOG_2_WIDTH (LOG_2_WIDTH)
    ) u_bit_reverse_index (
        .i_idx (w_k_inc),
        .o_idx (w_src)
    );
`else
    assign w_src = w_k_inc;
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and datapath strobes
    // ------------------------------------------------------------------------
    // Capture is qualified by the registered frame_ready so that the cycle
    // right after reset, where ready is still low, never accepts a frame.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.frame_valid && r_frame_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                // out_valid is high throughout STREAM, so out_ready alone
                // completes a handshake here.
                if (bus.out_ready) begin
                    if (r_k == c_last_k) begin
                        w_finish     = 1'b1;
                        w_next_state = IDLE;
                    end else begin
                        w_advance    = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output registers and beat counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_ready <= 1'b0;
            r_k           <= '0;
            r_out_re      <= '0;
            r_out_im      <= '0;
            r_out_last    <= 1'b0;
        end else begin
            r_frame_ready <= (w_next_state == IDLE);
            if (w_capture) begin
                // Beat 0 comes straight off the input arrays since the buffer
                // is being written on this same edge; bitrev(0) is 0, so both
                // builds read entry 0.
                r_k        <= '0;
                r_out_re   <= bus.frame_Re[0];
                r_out_im   <= bus.frame_Im[0];
                r_out_last <= 1'b0;
            end else if (w_advance) begin
                r_k        <= w_k_inc;
                r_out_re   <= r_buf_re[w_src];
                r_out_im   <= r_buf_im[w_src];
                r_out_last <= (w_k_inc == c_last_k);
            end else if (w_finish) begin
                r_k        <= '0;
                r_out_last <= 1'b0;
            end
        end
    end

    // Frame buffer: contents are don't-care after reset, so it carries none.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < D_WIDTH; i++) begin
                r_buf_re[i] <= bus.frame_Re[i];
                r_buf_im[i] <= bus.frame_Im[i];
            end
        end
    end

    assign bus.frame_ready = r_frame_ready;
    assign bus.out_valid   = (r_state == STREAM);
    assign bus.busy        = (r_state == STREAM);
    assign bus.out_Re      = r_out_re;
    assign bus.out_Im      = r_out_im;
    assign bus.out_index   = r_k;
    assign bus.out_last    = r_out_last;

endmodule : fft_result_streamer
`default_nettype wire
